bcd_score_counter: RTL and testbench



---
 rtl/bcd_score_counter.sv | 113 +++++++++++
 tb/tb_bcd_score_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_counter.sv
// Packed-BCD game score counter with persistent high score, milestone pulse,
// overflow flag and a freeze-on-game-over FSM for the Dino display path.
module bcd_score_counter #(
    parameter int DIGITS          = 4,
    parameter int MILESTONE_DIGIT = 2,
    parameter bit SATURATE        = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                run,
    input  logic                clear,
    input  logic                game_over,
    output logic [4*DIGITS-1:0] score,
    output logic [4*DIGITS-1:0] hi_score,
    output logic                milestone,
    output logic                new_record,
    output logic                overflow,
    output logic                frozen
);

    localparam int W = 4 * DIGITS;

    typedef enum logic {
        ACTIVE = 1'b0,
        FROZEN = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   inc_val;
    logic           carry;
    logic           all_nines;
    logic           milestone_hit;
    logic [W-1:0]   score_n;
    logic [W-1:0]   hi_score_n;
    logic           milestone_n;
    logic           new_record_n;
    logic           overflow_n;

    // Ripple the +1 through every trailing 9 so the whole carry chain settles in one cycle.
    always_comb begin
        inc_val = score;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    // Lower digits all zero after a non-overflowing increment means a carry entered the milestone digit.
    assign milestone_hit = (inc_val[4*MILESTONE_DIGIT-1:0] == '0) && !all_nines;

    always_comb begin
        state_n      = state;
        score_n      = score;
        hi_score_n   = hi_score;
        milestone_n  = 1'b0;
        new_record_n = new_record;
        overflow_n   = overflow;

        if (clear) begin
            state_n      = ACTIVE;
            score_n      = '0;
            overflow_n   = 1'b0;
            new_record_n = 1'b0;
        end else if (state == ACTIVE && game_over) begin
            state_n = FROZEN;
            if (score > hi_score) begin
                hi_score_n   = score;
                new_record_n = 1'b1;
            end else begin
                new_record_n = 1'b0;
            end
        end else if (state == ACTIVE && run && tick) begin
            if (all_nines) begin
                overflow_n = 1'b1;
                score_n    = SATURATE ? score : '0;
            end else begin
                score_n     = inc_val;
                milestone_n = milestone_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACTIVE;
            score      <= '0;
            hi_score   <= '0;
            milestone  <= 1'b0;
            new_record <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            score      <= score_n;
            hi_score   <= hi_score_n;
            milestone  <= milestone_n;
            new_record <= new_record_n;
            overflow   <= overflow_n;
        end
    end

    assign frozen = (state == FROZEN);

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed self-checking bench for bcd_score_counter: a saturating instance and a
// wrapping instance share every input so overflow behaviour can be compared side by side.
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        game_over = 1'b0;
    logic [15:0] score, hi_score, score_w, hi_score_w;
    logic        milestone, new_record, overflow, frozen;
    logic        milestone_w, new_record_w, overflow_w, frozen_w;

    int checks = 0;
    int errors = 0;

    bcd_score_counter #(.DIGITS(4), .MILESTONE_DIGIT(2), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .game_over(game_over),
        .score(score), .hi_score(hi_score), .milestone(milestone), .new_record(new_record),
        .overflow(overflow), .frozen(frozen)
    );

    bcd_score_counter #(.DIGITS(4), .MILESTONE_DIGIT(2), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .game_over(game_over),
        .score(score_w), .hi_score(hi_score_w), .milestone(milestone_w), .new_record(new_record_w),
        .overflow(overflow_w), .frozen(frozen_w)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cycle();
        tick = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic pulse_game_over();
        game_over = 1'b1;
        cycle();
        game_over = 1'b0;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; run = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        checks++; if (score !== 16'h0000) begin errors++; $display("[TB] FAIL reset_score: got %h want %h", score, 16'h0000); end
        checks++; if (hi_score !== 16'h0000) begin errors++; $display("[TB] FAIL reset_hi: got %h want %h", hi_score, 16'h0000); end
        checks++; if ({milestone, new_record, overflow, frozen} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", {milestone, new_record, overflow, frozen}); end
    endtask

    task automatic test_count();
        run = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick = 1'b1; cycle(); tick = 1'b0;
            checks++; if (score !== to_bcd(i)) begin errors++; $display("[TB] FAIL count_after_tick: got %h want %h", score, to_bcd(i)); end
            cycle();
            checks++; if (score !== to_bcd(i)) begin errors++; $display("[TB] FAIL count_idle_hold: got %h want %h", score, to_bcd(i)); end
        end
        checks++; if (score !== 16'h0012) begin errors++; $display("[TB] FAIL count_final: got %h want %h", score, 16'h0012); end
    endtask

    task automatic test_run_low();
        pulse_clear();
        run = 1'b0;
        ticks(5);
        checks++; if (score !== 16'h0000) begin errors++; $display("[TB] FAIL run_low_hold: got %h want %h", score, 16'h0000); end
        run = 1'b1;
    endtask

    task automatic test_milestone();
        int ms_count;
        pulse_clear();
        ticks(99);
        checks++; if (score !== 16'h0099) begin errors++; $display("[TB] FAIL preload_99: got %h want %h", score, 16'h0099); end
        checks++; if (milestone !== 1'b0) begin errors++; $display("[TB] FAIL ms_at_99: got %b want 0", milestone); end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++; if (score !== 16'h0100) begin errors++; $display("[TB] FAIL carry_100: got %h want %h", score, 16'h0100); end
        checks++; if (milestone !== 1'b1) begin errors++; $display("[TB] FAIL ms_at_100: got %b want 1", milestone); end
        cycle();
        checks++; if (milestone !== 1'b0) begin errors++; $display("[TB] FAIL ms_one_cycle: got %b want 0", milestone); end
        ms_count = 0;
        tick = 1'b1;
        repeat (899) begin
            cycle();
            if (milestone === 1'b1) ms_count++;
        end
        tick = 1'b0;
        checks++; if (score !== 16'h0999) begin errors++; $display("[TB] FAIL preload_999: got %h want %h", score, 16'h0999); end
        checks++; if (ms_count !== 8) begin errors++; $display("[TB] FAIL ms_count_100_999: got %0d want %0d", ms_count, 8); end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++; if (score !== 16'h1000) begin errors++; $display("[TB] FAIL carry_1000: got %h want %h", score, 16'h1000); end
        checks++; if (milestone !== 1'b1) begin errors++; $display("[TB] FAIL ms_at_1000: got %b want 1", milestone); end
    endtask

    task automatic test_overflow();
        ticks(8999);
        checks++; if (score !== 16'h9999 || score_w !== 16'h9999) begin errors++; $display("[TB] FAIL preload_9999: got %h/%h want 9999/9999", score, score_w); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before: got %b want 0", overflow); end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++; if (score !== 16'h9999) begin errors++; $display("[TB] FAIL sat_hold: got %h want %h", score, 16'h9999); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL sat_ovf: got %b want 1", overflow); end
        checks++; if (milestone !== 1'b0 || milestone_w !== 1'b0) begin errors++; $display("[TB] FAIL ovf_no_ms: got %b/%b want 0/0", milestone, milestone_w); end
        checks++; if (score_w !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h want %h", score_w, 16'h0000); end
        checks++; if (overflow_w !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ovf: got %b want 1", overflow_w); end
        tick = 1'b1; cycle(); tick = 1'b0;
        checks++; if (score !== 16'h9999 || score_w !== 16'h0001) begin errors++; $display("[TB] FAIL post_ovf_tick: got %h/%h want 9999/0001", score, score_w); end
        checks++; if (overflow !== 1'b1 || overflow_w !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b/%b want 1/1", overflow, overflow_w); end
        pulse_clear();
        checks++; if (overflow !== 1'b0 || overflow_w !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b/%b want 0/0", overflow, overflow_w); end
        checks++; if (score !== 16'h0000) begin errors++; $display("[TB] FAIL clear_score: got %h want %h", score, 16'h0000); end
    endtask

    task automatic test_game_over();
        ticks(42);
        pulse_game_over();
        checks++; if (frozen !== 1'b1) begin errors++; $display("[TB] FAIL go_frozen: got %b want 1", frozen); end
        checks++; if (hi_score !== 16'h0042) begin errors++; $display("[TB] FAIL go_hi: got %h want %h", hi_score, 16'h0042); end
        checks++; if (new_record !== 1'b1) begin errors++; $display("[TB] FAIL go_record: got %b want 1", new_record); end
        ticks(3);
        pulse_game_over();
        checks++; if (score !== 16'h0042) begin errors++; $display("[TB] FAIL frozen_hold: got %h want %h", score, 16'h0042); end
        checks++; if (new_record !== 1'b1 || frozen !== 1'b1) begin errors++; $display("[TB] FAIL frozen_second_go: got %b%b want 11", new_record, frozen); end
    endtask

    task automatic test_records();
        pulse_clear();
        checks++; if (frozen !== 1'b0 || new_record !== 1'b0) begin errors++; $display("[TB] FAIL clear_flags: got %b%b want 00", frozen, new_record); end
        checks++; if (hi_score !== 16'h0042) begin errors++; $display("[TB] FAIL hi_retained: got %h want %h", hi_score, 16'h0042); end
        ticks(42);
        pulse_game_over();
        checks++; if (hi_score !== 16'h0042 || new_record !== 1'b0) begin errors++; $display("[TB] FAIL tie_no_record: got %h/%b want 0042/0", hi_score, new_record); end
        pulse_clear();
        ticks(43);
        pulse_game_over();
        checks++; if (hi_score !== 16'h0043 || new_record !== 1'b1) begin errors++; $display("[TB] FAIL new_record_43: got %h/%b want 0043/1", hi_score, new_record); end
    endtask

    task automatic test_simultaneous();
        pulse_clear();
        ticks(5);
        clear = 1'b1; tick = 1'b1; cycle(); clear = 1'b0; tick = 1'b0;
        checks++; if (score !== 16'h0000) begin errors++; $display("[TB] FAIL clear_with_tick: got %h want %h", score, 16'h0000); end
        ticks(43);
        game_over = 1'b1; tick = 1'b1; cycle(); game_over = 1'b0; tick = 1'b0;
        checks++; if (score !== 16'h0043 || hi_score !== 16'h0043 || new_record !== 1'b0) begin errors++; $display("[TB] FAIL go_tick_tie: got %h/%h/%b want 0043/0043/0", score, hi_score, new_record); end
        rst = 1'b1; cycle(); rst = 1'b0;
        checks++; if (score !== 16'h0000 || hi_score !== 16'h0000) begin errors++; $display("[TB] FAIL rst_frozen_scores: got %h/%h want 0000/0000", score, hi_score); end
        checks++; if ({milestone, new_record, overflow, frozen} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_frozen_flags: got %b want 0000", {milestone, new_record, overflow, frozen}); end
        ticks(10);
        game_over = 1'b1; tick = 1'b1; cycle(); game_over = 1'b0; tick = 1'b0;
        checks++; if (score !== 16'h0010 || hi_score !== 16'h0010) begin errors++; $display("[TB] FAIL go_tick_10: got %h/%h want 0010/0010", score, hi_score); end
        checks++; if (new_record !== 1'b1 || frozen !== 1'b1) begin errors++; $display("[TB] FAIL go_tick_flags: got %b%b want 11", new_record, frozen); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_run_low();
        test_milestone();
        test_overflow();
        test_game_over();
        test_records();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
